ps2_key_decoder: RTL
====================

# ps2_key_decoder

Consumes the byte stream produced by the PS/2 frame receiver and turns PS/2 Set 2 scan-code sequences into key events. It tracks the E0 (extended) and F0 (break) prefixes, holds the currently pressed key, suppresses typematic repeats from the press counter, and provides an ASCII code for letters and digits. Its outputs drive the seven-segment display and the key-count logic downstream.

## Interface

- `TIMEOUT_CYCLES`, default 500000: clock cycles a prefix may wait for its next byte before the sequence is abandoned; must be ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `code`  in  8  received scan-code byte, valid only when `code_valid` = 1.
- `code_valid`  in  1  one-cycle strobe per accepted, parity-checked frame from the receiver.
- `key_code`  out  8  scan code of the last key pressed, without the prefix.
- `key_ext`  out  1  1 if the last pressed key was E0-extended.
- `key_pressed`  out  1  level; 1 while that key is held.
- `ascii`  out  8  ASCII code of `key_code`; 0x00 when unmapped or extended.
- `press_pulse`  out  1  one-cycle pulse on each new key press.
- `release_pulse`  out  1  one-cycle pulse when the held key is released.
- `repeat_pulse`  out  1  one-cycle pulse on each typematic repeat of the held key.
- `press_count`  out  8  count of new presses, modulo 256.

## Operation

- Prefix FSM states: IDLE, E0, F0, E0F0. It advances only on a cycle with `code_valid` = 1.
- From IDLE:
  - 0xE0 → E0.
  - 0xF0 → F0.
  - Any other byte → make event (ext = 0).
- From E0:
  - 0xF0 → E0F0.
  - 0xE0 → stay in E0.
  - Any other byte → make event (ext = 1), then IDLE.
- From F0:
  - 0xF0 → stay in F0.
  - 0xE0 → E0F0.
  - Any other byte → break event (ext = 0), then IDLE.
- From E0F0:
  - 0xE0 or 0xF0 → stay in E0F0.
  - Any other byte → break event (ext = 1), then IDLE.
- Make event with `key_pressed` = 1 and {`key_ext`,`key_code`} equal to {ext,code}: this is a repeat.
  - `repeat_pulse` = 1.
  - No other output changes.
- Any other make event is a new press:
  - `key_code` ← code, `key_ext` ← ext, `key_pressed` ← 1.
  - `ascii` ← table(code, ext).
  - `press_pulse` = 1.
  - `press_count` increments, wrapping 0xFF → 0x00.
  - A new press while another key is held replaces the held key. No release pulse is generated for the old key.
- Break event matching the held {ext,code}: `key_pressed` ← 0 and `release_pulse` = 1.
- Break event not matching the held key: ignored. `key_code`, `key_ext` and `ascii` keep their last values after release.
- ASCII table applies only when ext = 0. All other codes map to 0x00.
  - Letters (lowercase): a 1C, b 32, c 21, d 23, e 24, f 2B, g 34, h 33, i 43, j 3B, k 42, l 4B, m 3A, n 31, o 44, p 4D, q 15, r 2D, s 1B, t 2C, u 3C, v 2A, w 1D, x 22, y 35, z 1A.
  - Digits: 0 45, 1 16, 2 1E, 3 26, 4 25, 5 2E, 6 36, 7 3D, 8 3E, 9 46.
- Timeout:
  - A counter runs while the FSM is in any non-IDLE state. It clears on every `code_valid` and on entry to IDLE.
  - When the counter reaches `TIMEOUT_CYCLES` - 1, the FSM returns to IDLE and no event is generated.
  - Counter width is $clog2(`TIMEOUT_CYCLES`).

## Timing

- All outputs are registered. For a `code_valid` sampled at edge N:
  - The FSM state updates at edge N.
  - Event outputs are visible after edge N; latency is 1 cycle.
- Pulses are high for exactly one cycle. At most one of press, release or repeat pulse is asserted per cycle.
- A prefix byte produces no pulse and no output change.
- Back-to-back `code_valid` on consecutive cycles must be handled: one byte per cycle, no loss.
- Reset:
  - Reset values: state IDLE, all outputs 0 (`key_code` 0x00, `ascii` 0x00, `press_count` 0x00), timeout counter 0.
  - `code_valid` is ignored in any cycle where `reset` = 1.
  - Reset mid-sequence (e.g. after E0) discards the prefix.

## Test plan

- After reset, send 1C, F0, 1C → `press_pulse` once; `key_code` = 0x1C, `ascii` = 0x61, `press_count` = 1; then `release_pulse` once, `key_pressed` = 0, `ascii` stays 0x61.
- Send 1C, 1C, 1C, F0, 1C → one press, two `repeat_pulse`s, `press_count` = 1, one release.
- Send E0, 75, E0, F0, 75 → `key_ext` = 1, `key_code` = 0x75, `ascii` = 0x00; then a release with `key_pressed` = 0.
- With `TIMEOUT_CYCLES` = 16, send F0 and wait 20 cycles, then send 16 → a press of 0x16 (`ascii` 0x31), not a break.
- Send 256 distinct press/release pairs → `press_count` wraps to 0x00. Assert `reset` between F0 and its code byte, then send 1C → a press occurs.
- Press 1C then 32 without a release, then F0 1C → `key_code` = 0x32, no release pulse; then F0 32 → `release_pulse`.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 Set 2 scan-code decoder: tracks E0/F0 prefixes, holds the pressed key,
// separates typematic repeats from new presses and maps letters/digits to ASCII.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] code,
  input  logic       code_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_pressed,
  output logic [7:0] ascii,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic [7:0] press_count
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]       SC_E0    = 8'hE0;
  localparam logic [7:0]       SC_F0    = 8'hF0;

  typedef enum logic [1:0] {S_IDLE, S_E0, S_F0, S_E0F0} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             w_is_e0;
  logic             w_is_f0;
  logic             w_make;
  logic             w_break;
  logic             w_ext;
  logic             w_match;

  function automatic logic [7:0] f_ascii(input logic [7:0] sc, input logic ext);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      case (sc)
        8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
        8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
        8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
        8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
        8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
        8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
        8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
        8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
        8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
        8'h3E: a = 8'h38; 8'h46: a = 8'h39;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

  assign w_is_e0 = (code == SC_E0);
  assign w_is_f0 = (code == SC_F0);
  assign w_match = key_pressed && (key_ext == w_ext) && (key_code == code);

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_break     = 1'b0;
    w_ext       = 1'b0;
    if (code_valid) begin
      case (r_state)
        S_IDLE: begin
          if (w_is_e0)      w_state_nxt = S_E0;
          else if (w_is_f0) w_state_nxt = S_F0;
          else              w_make      = 1'b1;
        end
        S_E0: begin
          w_ext = 1'b1;
          if (w_is_f0)       w_state_nxt = S_E0F0;
          else if (!w_is_e0) begin
            w_make      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        S_F0: begin
          if (w_is_e0)       w_state_nxt = S_E0F0;
          else if (!w_is_f0) begin
            w_break     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_ext = 1'b1;
          if (!w_is_e0 && !w_is_f0) begin
            w_break     = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      endcase
    end else if (r_state != S_IDLE && r_tmo_cnt == CNT_LAST) begin
      // Abandoned prefix: drop back without producing an event.
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_tmo_cnt     <= '0;
      key_code      <= 8'h00;
      key_ext       <= 1'b0;
      key_pressed   <= 1'b0;
      ascii         <= 8'h00;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      press_count   <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
      if (code_valid || w_state_nxt == S_IDLE) r_tmo_cnt <= '0;
      else                                     r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
      if (w_make) begin
        if (w_match) begin
          repeat_pulse <= 1'b1;
        end else begin
          key_code    <= code;
          key_ext     <= w_ext;
          key_pressed <= 1'b1;
          ascii       <= f_ascii(code, w_ext);
          press_pulse <= 1'b1;
          press_count <= press_count + 8'd1;
        end
      end else if (w_break && w_match) begin
        key_pressed   <= 1'b0;
        release_pulse <= 1'b1;
      end
    end
  end

endmodule
